// File: rtl/countdown_ctrl.sv
// Countdown-alarm sequencer: assembles an HH:MM:SS BCD target from keypad digits,
// counts it down on a prescaled 1 Hz tick and holds the alarm for ALARM_TICKS seconds.
module countdown_ctrl #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       cmd_load,
  input  logic       cmd_start,
  input  logic       cmd_pause,
  input  logic       cmd_clear,
  output logic [2:0] state,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [2:0] digit_pos,
  output logic       alarm,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ENTRY = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] PAUSE = 3'd4;
  localparam logic [2:0] ALARM = 3'd5;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [2:0]    pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          done_q, done_d, err_q, err_d;

  logic       tick, value_zero, bad_digit, clr_val;
  logic       ss_borrow, mm_borrow;
  logic [7:0] hh_n, mm_n, ss_n;

  // Decrement one BCD pair; 00 wraps to {wrap_tens,9} (the caller handles the borrow).
  function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [3:0] wrap_tens);
    if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {wrap_tens, 4'd9};
  endfunction

  assign tick       = (presc_q == PRESC_MAX);
  assign value_zero = ({hh_q, mm_q, ss_q} == 24'd0);
  assign bad_digit  = (key_digit > 4'd9) ||
                      (((pos_q == 3'd2) || (pos_q == 3'd4)) && (key_digit > 4'd5));
  assign ss_borrow  = (ss_q == 8'h00);
  assign mm_borrow  = ss_borrow && (mm_q == 8'h00);
  assign ss_n       = dec_bcd(ss_q, 4'd5);
  assign mm_n       = ss_borrow ? dec_bcd(mm_q, 4'd5) : mm_q;
  assign hh_n       = mm_borrow ? dec_bcd(hh_q, 4'd9) : hh_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr_val = 1'b0;

    // Only commands meaningful in the current state take part in the priority chain.
    case (state_q)
      IDLE: begin
        if (cmd_clear)     clr_val = 1'b1;
        else if (cmd_load) begin state_d = ENTRY; clr_val = 1'b1; end
      end
      ENTRY: begin
        if (cmd_clear)      begin state_d = IDLE; clr_val = 1'b1; end
        else if (cmd_load)  clr_val = 1'b1;
        else if (key_valid) begin
          if (bad_digit) err_d = 1'b1;
          else begin
            case (pos_q)
              3'd0:    hh_d[7:4] = key_digit;
              3'd1:    hh_d[3:0] = key_digit;
              3'd2:    mm_d[7:4] = key_digit;
              3'd3:    mm_d[3:0] = key_digit;
              3'd4:    ss_d[7:4] = key_digit;
              default: ss_d[3:0] = key_digit;
            endcase
            if (pos_q == 3'd5) begin state_d = ARMED; pos_d = 3'd0; end
            else pos_d = pos_q + 3'd1;
          end
        end
      end
      ARMED: begin
        if (cmd_clear)      begin state_d = IDLE;  clr_val = 1'b1; end
        else if (cmd_load)  begin state_d = ENTRY; clr_val = 1'b1; end
        else if (cmd_start) begin
          if (value_zero) err_d = 1'b1;
          else begin state_d = RUN; presc_d = '0; end
        end
      end
      RUN: begin
        if (cmd_clear)      begin state_d = IDLE;  clr_val = 1'b1; end
        else if (cmd_load)  begin state_d = ENTRY; clr_val = 1'b1; end
        else if (cmd_pause) state_d = PAUSE;
        else if (tick) begin
          presc_d = '0;
          hh_d    = hh_n;
          mm_d    = mm_n;
          ss_d    = ss_n;
          if ({hh_n, mm_n, ss_n} == 24'd0) begin
            state_d = ALARM;
            done_d  = 1'b1;
            acnt_d  = '0;
          end
        end else presc_d = presc_q + 1'b1;
      end
      PAUSE: begin
        if (cmd_clear)      begin state_d = IDLE;  clr_val = 1'b1; end
        else if (cmd_load)  begin state_d = ENTRY; clr_val = 1'b1; end
        else if (cmd_start) state_d = RUN;
      end
      ALARM: begin
        if (cmd_clear)     begin state_d = IDLE;  clr_val = 1'b1; end
        else if (cmd_load) begin state_d = ENTRY; clr_val = 1'b1; end
        else if (tick) begin
          presc_d = '0;
          if (acnt_q == ALARM_LAST) begin state_d = IDLE; clr_val = 1'b1; end
          else acnt_d = acnt_q + 1'b1;
        end else presc_d = presc_q + 1'b1;
      end
      default: begin state_d = IDLE; clr_val = 1'b1; end
    endcase

    if (clr_val) begin
      hh_d    = 8'h00;
      mm_d    = 8'h00;
      ss_d    = 8'h00;
      pos_d   = 3'd0;
      presc_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      pos_q   <= 3'd0;
      presc_q <= '0;
      acnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign state     = state_q;
  assign hh_bcd    = hh_q;
  assign mm_bcd    = mm_q;
  assign ss_bcd    = ss_q;
  assign digit_pos = pos_q;
  assign alarm     = (state_q == ALARM);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the countdown-alarm datapath: it takes decoded keypad digits, assembles an HH:MM:SS target in BCD, and runs the countdown from a 1 Hz prescaled tick. It drives the alarm output when the count reaches zero. It sits between the keypad/button edge-detect logic and the 7-segment display driver, and owns all mode sequencing (load, armed, run, pause, alarm).

## Interface
- TICK_DIV, 50_000_000, clk cycles per countdown second (≥2)
- ALARM_TICKS, 10, seconds alarm stays asserted before auto-return to IDLE (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  one-cycle pulse, key_digit valid
- key_digit  in  4  decoded digit; values 10-15 are illegal
- cmd_load  in  1  one-cycle pulse, enter digit entry
- cmd_start  in  1  one-cycle pulse, start or resume
- cmd_pause  in  1  one-cycle pulse, pause
- cmd_clear  in  1  one-cycle pulse, abort to IDLE
- state  out  3  IDLE=0, ENTRY=1, ARMED=2, RUN=3, PAUSE=4, ALARM=5
- hh_bcd, mm_bcd, ss_bcd  out  8 each  current value, {tens,units} BCD
- digit_pos  out  3  next entry position 0..5 (H1,H0,M1,M0,S1,S0)
- alarm  out  1  high throughout ALARM
- done  out  1  one-cycle pulse on entry to ALARM
- err  out  1  one-cycle pulse on a rejected digit or start

## Operation
- Reset: state=IDLE, all BCD=0, digit_pos=0, prescaler=0, alarm/done/err=0.
- Command priority within one cycle: cmd_clear > cmd_load > cmd_pause > cmd_start > key_valid > tick. Only the highest-priority event is acted on; the rest are ignored.
- IDLE: cmd_load → ENTRY, value cleared, digit_pos=0. All other inputs are ignored.
- ENTRY: key_valid writes key_digit at digit_pos, then digit_pos+1.
  - A digit is rejected (err pulse, no write, position held) if key_digit>9, or if it is at M1/S1 and key_digit>5.
  - Write at pos 5 → ARMED, digit_pos returns to 0.
  - cmd_load or cmd_clear in ENTRY: cmd_clear → IDLE; cmd_load restarts entry (value cleared, pos 0).
- ARMED: cmd_start with value ≠ 0 → RUN, prescaler=0. cmd_start with value = 0 → err pulse, stay in ARMED. cmd_load → ENTRY (cleared). cmd_clear → IDLE, value cleared.
- RUN: the prescaler counts 0..TICK_DIV-1, and tick fires at TICK_DIV-1. On tick the value decrements by one second:
  - ss units borrow chain; ss 00 → 59 with borrow into mm.
  - mm 00 → 59 with borrow into hh.
  - hh 00..99.
  - A decrement producing 00:00:00 → ALARM, done pulse, prescaler=0.
  - cmd_pause → PAUSE, prescaler held. cmd_start is ignored. cmd_load → ENTRY. cmd_clear → IDLE.
- PAUSE: value and prescaler frozen. cmd_start → RUN, resuming the held prescaler count. cmd_clear → IDLE. cmd_load → ENTRY.
- ALARM: alarm=1, value 00:00:00. The prescaler keeps running and ticks are counted. After ALARM_TICKS ticks → IDLE. cmd_clear or cmd_load exits early (to IDLE or ENTRY respectively). cmd_start and cmd_pause are ignored.
- Every entry to IDLE clears the value and digit_pos. key_valid outside ENTRY is ignored without err.

## Timing
- All outputs are registered and update on the clk edge that samples the event; a pulse is visible for exactly the following cycle.
- The first tick after RUN entry from ARMED lands TICK_DIV cycles after the cmd_start edge.
- The state change to ALARM, value=0, and done all appear in the same cycle. alarm=1 in that cycle.
- done and err never assert together in one cycle; done is never re-asserted while in ALARM.
- Asynchronous reset mid-operation (any state, mid-prescale) returns all outputs to their reset values immediately; there is no residual pulse after release.
- An event coincident with tick follows the priority list: cmd_pause on a tick cycle pauses without decrementing.

## Test plan
- Entry: cmd_load, keys 0,0,0,1,0,5 → state ARMED, hh/mm/ss = 0x00/0x01/0x05, err never asserted.
- Validation: in ENTRY at pos 2, key 7 → err one cycle, digit_pos stays 2. Key 12 at pos 0 → err. cmd_start in ARMED with 00:00:00 → err, state stays 2.
- Countdown/borrow (TICK_DIV=4): load 01:00:00, start → after 4 cycles 00:59:59. Load 00:00:02 → done pulse 8 cycles after start, state ALARM, alarm=1.
- Pause/resume (TICK_DIV=4): start, cmd_pause at prescaler=2, wait 20 cycles with value unchanged, cmd_start → next tick 2 cycles later.
- Alarm timeout (TICK_DIV=4, ALARM_TICKS=3): alarm high exactly 12 cycles, then IDLE with alarm=0. A separate run with cmd_clear during ALARM → IDLE next cycle.
- Priority/reset: cmd_clear and cmd_start in the same cycle in ARMED → IDLE. reset asserted in RUN mid-prescale → state 0, BCD 0, no pulses after release.
